// File: rtl/apb_master.sv
// Single-transfer APB master: accepts host commands and runs one APB transfer at a time.
// Optional ACCESS wait-state timeout is compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,

    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);

    // state  | meaning
    // IDLE   | cmd_ready high, waiting for a host command
    // SETUP  | APB setup phase (PSELx=1, PENABLE=0), one cycle
    // ACCESS | APB access phase, waits for PREADY (or timeout)
    // RESP   | response presented until the host takes it
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_d;
    logic                  psel_d;
    logic                  penable_d;
    logic                  pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_d;
    logic                  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  rsp_slverr_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int                CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    // Down-counter of remaining wait cycles; terminal count zero ends the transfer.
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_timeout_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign rsp_timeout        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready;
        psel_d       = PSELx;
        penable_d    = PENABLE;
        pwrite_d     = PWRITE;
        paddr_d      = PADDR;
        pwdata_d     = PWDATA;
        pstrb_d      = PSTRB;
        rsp_valid_d  = rsp_valid;
        rsp_rdata_d  = rsp_rdata;
        rsp_slverr_d = rsp_slverr;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        rsp_timeout_d = rsp_timeout;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    paddr_d     = cmd_addr;
                    pwrite_d    = cmd_write;
                    pwdata_d    = cmd_wdata;
                    pstrb_d     = cmd_write ? cmd_strb : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                tmo_cnt_d = CNT_LOAD;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d      = RESP;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_slverr_d = PSLVERR;
                    rsp_rdata_d  = PWRITE ? '0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                    tmo_cnt_d     = '0;
                end else if (tmo_cnt_q == '0) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    tmo_cnt_d     = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - CNT_W'(1);
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            cmd_ready  <= 1'b1;
            PSELx      <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            PSTRB      <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_ready  <= cmd_ready_d;
            PSELx      <= psel_d;
            PENABLE    <= penable_d;
            PWRITE     <= pwrite_d;
            PADDR      <= paddr_d;
            PWDATA     <= pwdata_d;
            PSTRB      <= pstrb_d;
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rsp_rdata_d;
            rsp_slverr <= rsp_slverr_d;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout <= rsp_timeout_d;
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: slave model driven on the falling edge, responses checked
// against a queue of expected results filled when each command is issued.
module tb_apb_master;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic [31:0] PADDR;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;

    int          slv_wait  = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err   = 1'b0;
    int          acc_n     = 0;

    apb_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .STRB_WIDTH    (4),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .rsp_timeout(rsp_timeout),
        .PADDR      (PADDR),
        .PSELx      (PSELx),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA),
        .PSLVERR    (PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Slave: PREADY rises after slv_wait ACCESS cycles of the current transfer.
    initial begin
        PREADY  = 1'b0;
        PRDATA  = '0;
        PSLVERR = 1'b0;
        forever begin
            @(negedge PCLK);
            if (PSELx && PENABLE) begin
                PREADY = (acc_n >= slv_wait);
                acc_n++;
            end else begin
                PREADY = 1'b0;
                acc_n  = 0;
            end
            PRDATA  = slv_rdata;
            PSLVERR = slv_err;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge PCLK);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
        total++;
        if ({PSELx, PENABLE, PWRITE, rsp_valid, rsp_slverr, rsp_timeout} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {PSELx, PENABLE, PWRITE, rsp_valid, rsp_slverr, rsp_timeout});
        end
        total++;
        if ({PADDR, PWDATA, PSTRB, rsp_rdata} !== 100'b0) begin
            bad++;
            $display("FAIL reset_data: got %h %h %h %h want all zero", PADDR, PWDATA, PSTRB, rsp_rdata);
        end
        PRESET = 1'b0;
        @(negedge PCLK);
        total++;
        if (cmd_ready !== 1'b1 || PSELx !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: got ready=%b psel=%b want 1 0", cmd_ready, PSELx);
        end
    endtask

    // Runs one transfer from IDLE; called at a falling edge.
    task automatic run_txn(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb, input int wait_n,
                           input logic [31:0] prdata, input logic perr, input logic exp_to,
                           input int exp_lat, input int hold);
        exp_t        e;
        exp_t        got;
        logic [3:0]  exp_strb;
        int          lat;
        int          stable_n;
        int          en_n;
        bit          seen;
        e.rdata   = (wr || exp_to) ? 32'h0 : prdata;
        e.slverr  = perr || exp_to;
        e.timeout = exp_to;
        sb.push_back(e);
        exp_strb  = wr ? strb : 4'h0;
        slv_wait  = wait_n;
        slv_rdata = prdata;
        slv_err   = perr;

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_cmd_ready: got %b want 1", name, cmd_ready);
        end
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
        cmd_strb  = ~strb;
        total++;
        if ({PSELx, PENABLE} !== 2'b10) begin
            bad++;
            $display("FAIL %s_setup: got psel/penable=%b want 10", name, {PSELx, PENABLE});
        end
        lat      = 1;
        stable_n = 0;
        en_n     = 0;
        seen     = 1'b0;
        while (lat < 300) begin
            if (PSELx && PADDR === addr && PWRITE === wr && PWDATA === wdata && PSTRB === exp_strb)
                stable_n++;
            if (PENABLE)
                en_n++;
            @(negedge PCLK);
            lat++;
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_rsp_wait: no rsp_valid within %0d cycles", name, lat);
            return;
        end
        total++;
        if (lat !== exp_lat) begin
            bad++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
        end
        total++;
        if (stable_n !== exp_lat - 1 || en_n !== exp_lat - 2) begin
            bad++;
            $display("FAIL %s_apb_phase: stable=%0d penable=%0d want %0d %0d",
                     name, stable_n, en_n, exp_lat - 1, exp_lat - 2);
        end
        total++;
        if ({PSELx, PENABLE} !== 2'b00) begin
            bad++;
            $display("FAIL %s_resp_psel: got %b want 00", name, {PSELx, PENABLE});
        end
        for (int h = 1; h < hold; h++) begin
            @(negedge PCLK);
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_slverr !== e.slverr) begin
                bad++;
                $display("FAIL %s_hold: cycle %0d valid=%b rdata=%h err=%b", name, h,
                         rsp_valid, rsp_rdata, rsp_slverr);
            end
        end
        rsp_ready = 1'b1;
        got = sb.pop_front();
        total++;
        if (rsp_rdata !== got.rdata || rsp_slverr !== got.slverr || rsp_timeout !== got.timeout) begin
            bad++;
            $display("FAIL %s_response: got rdata=%h err=%b to=%b want rdata=%h err=%b to=%b",
                     name, rsp_rdata, rsp_slverr, rsp_timeout, got.rdata, got.slverr, got.timeout);
        end
        @(negedge PCLK);
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_back_idle: got valid=%b ready=%b want 0 1", name, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_zero_wait_write();
        run_txn("wr0", 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 3, 1);
        run_txn("wr_err", 1'b1, 32'h40, 32'h1234_0000, 4'h6, 0, 32'h7777_7777, 1'b1, 1'b0, 3, 1);
    endtask

    task automatic test_wait_read();
        run_txn("rd3", 1'b0, 32'h14, 32'h0BAD_0BAD, 4'hF, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 6, 1);
    endtask

    task automatic test_slave_error();
        run_txn("slverr", 1'b0, 32'hFFC, 32'h0, 4'h0, 0, 32'hCAFE_0001, 1'b1, 1'b0, 3, 4);
    endtask

    // cmd_valid and rsp_ready held high: transfers must be spaced by RESP + IDLE.
    task automatic test_back_to_back();
        logic [15:0] psel_seen;
        logic [15:0] psel_exp;
        exp_t        e;
        exp_t        got;
        slv_wait  = 0;
        slv_rdata = 32'h1234_5678;
        slv_err   = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h20;
        cmd_wdata = 32'h0;
        cmd_strb  = 4'h0;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            psel_exp[i]  = (i % 4 == 1) || (i % 4 == 2);
            psel_seen[i] = PSELx;
            if (rsp_valid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra_rsp: response at cycle %0d with nothing pending", i);
                end else begin
                    got = sb.pop_front();
                    if (rsp_rdata !== got.rdata || rsp_slverr !== got.slverr) begin
                        bad++;
                        $display("FAIL b2b_response: got rdata=%h err=%b want rdata=%h err=%b",
                                 rsp_rdata, rsp_slverr, got.rdata, got.slverr);
                    end
                end
            end
            if (cmd_ready === 1'b1 && i < 15) begin
                e.rdata   = slv_rdata;
                e.slverr  = 1'b0;
                e.timeout = 1'b0;
                sb.push_back(e);
            end
            if (i == 15)
                cmd_valid = 1'b0;
            @(negedge PCLK);
        end
        rsp_ready = 1'b0;
        total++;
        if (psel_seen !== psel_exp) begin
            bad++;
            $display("FAIL b2b_psel_pattern: got %b want %b", psel_seen, psel_exp);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL b2b_pending: got %0d outstanding want 0", sb.size());
        end
        @(negedge PCLK);
    endtask

    task automatic test_reset_mid_access();
        int rv_n;
        slv_wait  = 10;
        slv_rdata = 32'h5A5A_5A5A;
        slv_err   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h80;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        total++;
        if ({PSELx, PENABLE} !== 2'b11) begin
            bad++;
            $display("FAIL rst_mid_in_access: got %b want 11", {PSELx, PENABLE});
        end
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        total++;
        if ({PSELx, PENABLE, cmd_ready, rsp_valid} !== 4'b0010) begin
            bad++;
            $display("FAIL rst_mid_abort: got psel/pen/ready/valid=%b want 0010",
                     {PSELx, PENABLE, cmd_ready, rsp_valid});
        end
        rv_n = 0;
        repeat (12) begin
            @(negedge PCLK);
            if (rsp_valid !== 1'b0 || PSELx !== 1'b0)
                rv_n++;
        end
        total++;
        if (rv_n !== 0) begin
            bad++;
            $display("FAIL rst_mid_no_rsp: got %0d active cycles want 0", rv_n);
        end
    endtask

`ifdef APB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        run_txn("tmo", 1'b0, 32'h30, 32'h0, 4'h0, 1000, 32'h5555_AAAA, 1'b0, 1'b1, 6, 1);
        run_txn("tmo_edge", 1'b0, 32'h34, 32'h0, 4'h0, 3, 32'h5555_AAAA, 1'b0, 1'b0, 6, 1);
    endtask
`else
    task automatic test_no_timeout();
        run_txn("no_tmo", 1'b0, 32'h38, 32'h0, 4'h0, 100, 32'h0BAD_F00D, 1'b0, 1'b0, 103, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slave_error();
        test_back_to_back();
        test_reset_mid_access();
`ifdef APB_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of cmd_addr and PADDR.
REQ-002 Parameter DATA_WIDTH, default 32: width of write and read data.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8: width of cmd_strb and PSTRB.
REQ-004 Parameter TIMEOUT_CYCLES, default 16: wait-state limit, used only when the timeout feature is compiled in.
REQ-005 Clock port: PCLK  in  1  clock; the block SHALL use this single clock, rising edge only.
REQ-006 Reset port: PRESET  in  1  reset; reset SHALL be synchronous and active-high.
REQ-007 cmd_valid  in  1  host command request.
REQ-008 cmd_ready  out  1  block accepts a command.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_WIDTH  transfer address.
REQ-011 cmd_wdata  in  DATA_WIDTH  write data.
REQ-012 cmd_strb  in  STRB_WIDTH  write byte strobes.
REQ-013 rsp_valid  out  1  response available.
REQ-014 rsp_ready  in  1  host consumes the response.
REQ-015 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-016 rsp_slverr  out  1  transfer error.
REQ-017 rsp_timeout  out  1  transfer aborted by timeout.
REQ-018 APB ports: PADDR out ADDR_WIDTH; PSELx out 1; PENABLE out 1; PWRITE out 1; PWDATA out DATA_WIDTH; PSTRB out STRB_WIDTH; PREADY in 1; PRDATA in DATA_WIDTH; PSLVERR in 1.

Function
REQ-019 The FSM SHALL have four states, IDLE, SETUP, ACCESS and RESP, and all outputs SHALL be registered.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a PCLK edge where cmd_valid=1 and cmd_ready=1, with a transition to SETUP.
REQ-021 SETUP SHALL drive PSELx=1 and PENABLE=0, drive PADDR, PWRITE, PWDATA and PSTRB from the captured command, and move to ACCESS after exactly one cycle.
REQ-022 ACCESS SHALL drive PSELx=1 and PENABLE=1, and SHALL remain in ACCESS while PREADY=0.
REQ-023 PADDR, PWRITE, PWDATA and PSTRB SHALL be held constant from SETUP through the last ACCESS cycle.
REQ-024 PSTRB SHALL be driven 0 for read transfers.
REQ-025 On an ACCESS edge with PREADY=1, the block SHALL:
  - capture PSLVERR into rsp_slverr;
  - capture PRDATA into rsp_rdata for reads, or load 0 for writes;
  - deassert PSELx and PENABLE;
  - enter RESP.
REQ-026 RESP SHALL hold rsp_valid=1 and stable response fields until an edge with rsp_ready=1, then return to IDLE.
REQ-027 Zero-wait-state latency SHALL be: command accepted at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid=1 in cycle N+3; each PREADY=0 cycle SHALL add one cycle.
REQ-028 cmd_valid outside IDLE SHALL be ignored; rsp_ready outside RESP SHALL be ignored.
REQ-029 PSELx SHALL be 0 in IDLE and RESP, with no back-to-back APB transfers; the minimum spacing between transfers SHALL be RESP plus IDLE.

Reset
REQ-030 While PRESET=1 at an edge, the FSM SHALL enter IDLE, and every output except cmd_ready SHALL reset to 0; cmd_ready SHALL be 1 after reset.
REQ-031 Reset asserted in SETUP, ACCESS or RESP SHALL abort the transfer: PSELx and PENABLE SHALL be 0 on the next cycle, and no response SHALL be produced.

Configuration
REQ-032 Macro APB_MASTER_TIMEOUT_EN SHALL select the ACCESS timeout feature.
REQ-033 With APB_MASTER_TIMEOUT_EN defined, the block SHALL:
  - count consecutive ACCESS cycles with PREADY=0;
  - when the count reaches TIMEOUT_CYCLES, deassert PSELx and PENABLE, enter RESP with rsp_slverr=1, rsp_timeout=1 and rsp_rdata=0, and clear the counter;
  - when PREADY=1 occurs on the same edge the limit is reached, give PREADY priority, with a normal completion and rsp_timeout=0.
REQ-034 Without APB_MASTER_TIMEOUT_EN, ACCESS SHALL wait indefinitely, rsp_timeout SHALL be constant 0, and no counter logic SHALL be present.

Verification
REQ-035 Zero-wait write: cmd addr=0x10, wdata=0xA5A5_0001, strb=0xF, PREADY held 1 -> PSELx for 2 cycles, PENABLE in the 2nd, rsp_valid at N+3 with rsp_slverr=0 and rsp_rdata=0.
REQ-036 Read with 3 wait states: addr=0x14, PRDATA=0xDEAD_BEEF, PREADY low for 3 ACCESS cycles -> PADDR stable for 5 cycles, PSTRB=0, rsp_rdata=0xDEAD_BEEF at N+6.
REQ-037 Slave error: PSLVERR=1 with PREADY=1 on a read of addr=0xFFC -> rsp_slverr=1; rsp_valid held for 4 cycles while rsp_ready=0, then IDLE one cycle after rsp_ready=1.
REQ-038 Reset mid-ACCESS: PRESET=1 during the 2nd wait state -> next cycle PSELx=0, PENABLE=0, cmd_ready=1, and rsp_valid never asserts.
REQ-039 Timeout (macro defined, TIMEOUT_CYCLES=4): PREADY stuck at 0 -> after 4 ACCESS cycles, rsp_timeout=1, rsp_slverr=1, rsp_rdata=0; a repeat with PREADY=1 on the 4th cycle -> normal completion with rsp_timeout=0.
REQ-040 Timeout absent (macro undefined): PREADY=0 for 100 cycles -> the block stays in ACCESS with rsp_timeout=0, then completes normally when PREADY=1.
